// File: rtl/bayer_mosaic_encoder.sv
// RGB to RGGB Bayer raw encoder: frames the active image with zero lead/trail rows
// for the demosaic loopback path. One registered beat per lead/trail cycle or accepted pixel.
module bayer_mosaic_encoder #(
  parameter int width     = 1920,
  parameter int height    = 1080,
  parameter int leadRows  = 2,
  parameter int trailRows = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStart,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic        iValid,
  output logic        oReady,
  output logic [7:0]  oData,
  output logic        oValid,
  output logic        oSof,
  output logic        oDone,
  output logic [31:0] xCnt,
  output logic [31:0] yCnt,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEAD   = 2'd1,
    S_ACTIVE = 2'd2,
    S_TRAIL  = 2'd3
  } state_t;

  localparam logic [31:0] LEAD_BEATS  = 32'(leadRows * width);
  localparam logic [31:0] TRAIL_BEATS = 32'(trailRows * width);
  localparam logic [31:0] LEAD_LAST   = LEAD_BEATS - 32'd1;
  localparam logic [31:0] TRAIL_LAST  = TRAIL_BEATS - 32'd1;
  localparam logic [31:0] X_LAST      = 32'(width - 1);
  localparam logic [31:0] Y_LAST      = 32'(height - 1);
  localparam logic        LEAD_NONE   = (LEAD_BEATS == 32'd0);
  localparam logic        TRAIL_NONE  = (TRAIL_BEATS == 32'd0);

  state_t      state_q, state_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        done_q, done_d;

  // RGGB: even rows alternate R,G; odd rows alternate G,B.
  function automatic logic [7:0] bayer_pick(input logic row_odd, input logic col_odd,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
    logic [7:0] v;
    case ({row_odd, col_odd})
      2'b00:   v = r;
      2'b01:   v = g;
      2'b10:   v = g;
      2'b11:   v = b;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  assign oReady = (state_q == S_ACTIVE);
  assign oBusy  = (state_q != S_IDLE);
  assign oData  = data_q;
  assign oValid = valid_q;
  assign oSof   = sof_q;
  assign oDone  = done_q;
  assign xCnt   = x_q;
  assign yCnt   = y_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = 8'd0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    done_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          beat_d  = 32'd0;
          state_d = LEAD_NONE ? S_ACTIVE : S_LEAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD: begin
        valid_d = 1'b1;
        sof_d   = (beat_q == 32'd0);
        if (beat_q == LEAD_LAST) begin
          beat_d  = 32'd0;
          state_d = S_ACTIVE;
        end else begin
          beat_d = beat_q + 32'd1;
        end
      end
      S_ACTIVE: begin
        if (iValid) begin
          valid_d = 1'b1;
          // Without lead rows the frame starts at pixel (0,0).
          sof_d   = LEAD_NONE && (x_q == 32'd0) && (y_q == 32'd0);
          data_d  = bayer_pick(y_q[0], x_q[0], iR, iG, iB);
          if (x_q == X_LAST) begin
            x_d = 32'd0;
            if (y_q == Y_LAST) begin
              y_d     = 32'd0;
              beat_d  = 32'd0;
              done_d  = TRAIL_NONE;
              state_d = TRAIL_NONE ? S_IDLE : S_TRAIL;
            end else begin
              y_d = y_q + 32'd1;
            end
          end else begin
            x_d = x_q + 32'd1;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      S_TRAIL: begin
        valid_d = 1'b1;
        if (beat_q == TRAIL_LAST) begin
          beat_d  = 32'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          beat_d = beat_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      beat_q  <= 32'd0;
      x_q     <= 32'd0;
      y_q     <= 32'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bayer_mosaic_encoder.sv
// Bench for bayer_mosaic_encoder: two instances (lead/trail 2/1 and 0/0) share stimulus and
// are checked every cycle against a frame-position model, plus literal frame pins.
module tb_bayer_mosaic_encoder;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int LR0 = 2;
  localparam int TR0 = 1;
  localparam int LR1 = 0;
  localparam int TR1 = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_r = 8'd0, i_g = 8'd0, i_b = 8'd0;

  logic        a_ready, a_valid, a_sof, a_done, a_busy;
  logic        b_ready, b_valid, b_sof, b_done, b_busy;
  logic [7:0]  a_data, b_data;
  logic [31:0] a_x, a_y, b_x, b_y;

  logic [1:0]  d_ready, d_valid, d_sof, d_done, d_busy;
  logic [7:0]  d_data [2];
  logic [31:0] d_x [2];
  logic [31:0] d_y [2];
  assign d_ready = {b_ready, a_ready};
  assign d_valid = {b_valid, a_valid};
  assign d_sof   = {b_sof, a_sof};
  assign d_done  = {b_done, a_done};
  assign d_busy  = {b_busy, a_busy};
  assign d_data[0] = a_data;
  assign d_data[1] = b_data;
  assign d_x[0] = a_x;
  assign d_x[1] = b_x;
  assign d_y[0] = a_y;
  assign d_y[1] = b_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bayer_mosaic_encoder #(.width(W), .height(H), .leadRows(LR0), .trailRows(TR0)) dut_a (
    .clk(clk), .reset(reset), .iStart(i_start), .iR(i_r), .iG(i_g), .iB(i_b),
    .iValid(i_valid), .oReady(a_ready), .oData(a_data), .oValid(a_valid), .oSof(a_sof),
    .oDone(a_done), .xCnt(a_x), .yCnt(a_y), .oBusy(a_busy));

  bayer_mosaic_encoder #(.width(W), .height(H), .leadRows(LR1), .trailRows(TR1)) dut_b (
    .clk(clk), .reset(reset), .iStart(i_start), .iR(i_r), .iG(i_g), .iB(i_b),
    .iValid(i_valid), .oReady(b_ready), .oData(b_data), .oValid(b_valid), .oSof(b_sof),
    .oDone(b_done), .xCnt(b_x), .yCnt(b_y), .oBusy(b_busy));

  // Model: a frame is a list of beat positions; lead/trail positions are zeros, active ones pixels.
  bit m_idle [2] = '{1'b1, 1'b1};
  int m_p    [2] = '{0, 0};
  bit e_ready[2], e_valid[2], e_sof[2], e_done[2], e_busy[2];
  int e_data [2], e_x[2], e_y[2];

  logic [7:0] log_a[$];
  logic [7:0] log_b[$];
  int sof_idx[2], done_idx[2], ready_cnt[2], ready_first[2];
  int cyc;

  function automatic int lead_of(input int i);
    return (i == 0) ? LR0 : LR1;
  endfunction

  function automatic int trail_of(input int i);
    return (i == 0) ? TR0 : TR1;
  endfunction

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic model_step(input int i, input bit st, input bit v,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int a0, a1, total, k, x, y;
    bit emit;
    a0    = lead_of(i) * W;
    a1    = (lead_of(i) + H) * W;
    total = (lead_of(i) + H + trail_of(i)) * W;
    e_ready[i] = !m_idle[i] && (m_p[i] >= a0) && (m_p[i] < a1);
    e_valid[i] = 1'b0;
    e_sof[i]   = 1'b0;
    e_done[i]  = 1'b0;
    e_data[i]  = 0;
    if (m_idle[i]) begin
      if (st) begin
        m_idle[i] = 1'b0;
        m_p[i]    = 0;
      end
    end else begin
      emit = e_ready[i] ? v : 1'b1;
      if (emit) begin
        e_valid[i] = 1'b1;
        e_sof[i]   = (m_p[i] == 0);
        e_done[i]  = (m_p[i] == total - 1);
        if (e_ready[i]) begin
          k = m_p[i] - a0;
          x = k % W;
          y = k / W;
          if (y % 2 == 0) e_data[i] = (x % 2 == 0) ? int'(r) : int'(g);
          else            e_data[i] = (x % 2 == 0) ? int'(g) : int'(b);
        end
        m_p[i]++;
        if (m_p[i] == total) m_idle[i] = 1'b1;
      end
    end
    if (!m_idle[i] && (m_p[i] >= a0) && (m_p[i] < a1)) begin
      e_x[i] = (m_p[i] - a0) % W;
      e_y[i] = (m_p[i] - a0) / W;
    end else begin
      e_x[i] = 0;
      e_y[i] = 0;
    end
    e_busy[i] = !m_idle[i];
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
    for (int i = 0; i < 2; i++) begin
      sof_idx[i] = -1; done_idx[i] = -1; ready_cnt[i] = 0; ready_first[i] = -1;
    end
    cyc = 0;
  endtask

  // One clock: drive inputs, check oReady mid-cycle, then check registered outputs after the edge.
  task automatic step(input bit st, input bit v, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    int n;
    i_start = st; i_valid = v; i_r = r; i_g = g; i_b = b;
    #4;
    for (int i = 0; i < 2; i++) begin
      model_step(i, st, v, r, g, b);
      chk("ready", i, d_ready[i], e_ready[i]);
      if (d_ready[i]) begin
        ready_cnt[i]++;
        if (ready_first[i] < 0) ready_first[i] = cyc;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("valid", i, d_valid[i], e_valid[i]);
      if (e_valid[i]) chk("data", i, d_data[i], e_data[i]);
      chk("sof", i, d_sof[i], e_sof[i]);
      chk("done", i, d_done[i], e_done[i]);
      chk("xcnt", i, d_x[i], e_x[i]);
      chk("ycnt", i, d_y[i], e_y[i]);
      chk("busy", i, d_busy[i], e_busy[i]);
      if (d_valid[i]) begin
        if (i == 0) begin log_a.push_back(d_data[0]); n = log_a.size(); end
        else        begin log_b.push_back(d_data[1]); n = log_b.size(); end
        if (d_sof[i])  sof_idx[i]  = n - 1;
        if (d_done[i]) done_idx[i] = n - 1;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, d_valid[i], 0);
      chk("rst_data", i, d_data[i], 0);
      chk("rst_sof", i, d_sof[i], 0);
      chk("rst_done", i, d_done[i], 0);
      chk("rst_x", i, d_x[i], 0);
      chk("rst_y", i, d_y[i], 0);
      chk("rst_ready", i, d_ready[i], 0);
      chk("rst_busy", i, d_busy[i], 0);
      m_idle[i] = 1'b1;
      m_p[i]    = 0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Literal pins for R=10,G=20,B=30 frames.
  task automatic frame_check(input bit with_b);
    logic [7:0] act8 [8];
    logic [7:0] exp_a[$];
    act8 = '{8'd10, 8'd20, 8'd10, 8'd20, 8'd20, 8'd30, 8'd20, 8'd30};
    for (int k = 0; k < 8; k++) exp_a.push_back(8'd0);
    for (int k = 0; k < 8; k++) exp_a.push_back(act8[k]);
    for (int k = 0; k < 4; k++) exp_a.push_back(8'd0);
    chk("a_len", 0, log_a.size(), 20);
    for (int k = 0; k < 20; k++)
      if (k < log_a.size()) chk("a_beat", k, log_a[k], exp_a[k]);
    chk("a_sof_idx", 0, sof_idx[0], 0);
    chk("a_done_idx", 0, done_idx[0], 19);
    chk("a_ready_cnt", 0, ready_cnt[0], 8);
    chk("a_ready_first", 0, ready_first[0], 9);
    if (with_b) begin
      chk("b_len", 1, log_b.size(), 8);
      for (int k = 0; k < 8; k++)
        if (k < log_b.size()) chk("b_beat", k, log_b[k], act8[k]);
      chk("b_sof_idx", 1, sof_idx[1], 0);
      chk("b_done_idx", 1, done_idx[1], 7);
      chk("b_ready_cnt", 1, ready_cnt[1], 8);
      chk("b_ready_first", 1, ready_first[1], 1);
    end
  endtask

  initial begin
    logic [7:0] exp_tog [8];
    @(posedge clk);
    #1;
    do_reset();

    // Basic frame, iValid held high through IDLE and LEAD.
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 30; c++) step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30);
    frame_check(1'b1);
    chk("a_busy_end", 0, d_busy[0], 0);
    chk("b_busy_end", 1, d_busy[1], 0);

    // iStart pulsed while instance A is in ACTIVE is ignored.
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 30; c++) step(c == 12, 1'b1, 8'd10, 8'd20, 8'd30);
    frame_check(1'b0);

    // iStart in the last-beat cycle is ignored; one cycle later it restarts.
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 20; c++) step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30);
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    frame_check(1'b1);
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 30; c++) step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30);
    frame_check(1'b0);

    // Reset three pixels into ACTIVE, then a clean frame.
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 12; c++) step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30);
    chk("pre_rst_x", 0, d_x[0], 3);
    do_reset();
    clear_logs();
    step(1'b1, 1'b1, 8'd10, 8'd20, 8'd30);
    for (int c = 1; c < 30; c++) step(1'b0, 1'b1, 8'd10, 8'd20, 8'd30);
    frame_check(1'b1);

    // Alternating iValid with distinct pixels (R=c, G=c+50, B=c+100).
    clear_logs();
    for (int c = 0; c < 40; c++)
      step(c == 0, (c % 2) == 1, 8'(c), 8'(c + 50), 8'(c + 100));
    exp_tog = '{8'd9, 8'd61, 8'd13, 8'd65, 8'd67, 8'd119, 8'd71, 8'd123};
    chk("tog_len", 0, log_a.size(), 20);
    for (int k = 0; k < 8; k++)
      if (k + 8 < log_a.size()) chk("tog_beat", k, log_a[k + 8], exp_tog[k]);
    chk("tog_ready_cnt", 0, ready_cnt[0], 15);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
             8'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
